// File: rtl/dma_copy.sv
// dma_copy: byte block-copy engine in front of a 256 x 8 data memory.
// Idle/done: core memory traffic passes straight through.
// Busy: the engine owns the port and moves one byte every two cycles, first a
// combinational read and then a clocked write.
// Optional feature macro: DMA_COPY_FILL_EN. When it is defined, the `fill` and
// `fill_val` ports are added, and a fill writes a constant byte every cycle.
module dma_copy (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dat_in,
  input  logic       cpu_wr_en,
  input  logic [7:0] mem_dat_out,
`ifdef DMA_COPY_FILL_EN
  input  logic       fill,
  input  logic [7:0] fill_val,
`endif
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dat_in,
  output logic       mem_wr_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] src_r, dst_r, cnt, idx, data_buf;
  logic       wr_raw;
  logic       start_fill;
  logic       fill_mode;
  logic [7:0] fill_data;

`ifdef DMA_COPY_FILL_EN
  logic       fill_r;
  logic [7:0] fill_val_r;

  assign start_fill = fill;
  assign fill_mode  = fill_r;
  assign fill_data  = fill_val_r;

  // Fill request and fill byte are captured together with start.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_r     <= 1'b0;
      fill_val_r <= '0;
    end else if (state == IDLE && start) begin
      fill_r     <= fill;
      fill_val_r <= fill_val;
    end
  end
`else
  assign start_fill = 1'b0;
  assign fill_mode  = 1'b0;
  assign fill_data  = '0;
`endif

  // State register plus transfer bookkeeping (bases, remaining count, index, read buffer).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_r    <= '0;
      dst_r    <= '0;
      cnt      <= '0;
      idx      <= '0;
      data_buf <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_r <= src;
            dst_r <= dst;
            cnt   <= len;
            idx   <= '0;
          end
        end
        READ: data_buf <= mem_dat_out;
        WRITE: begin
          idx <= idx + 8'd1;
          cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and memory-port mux; reset gates the write enable so nothing is stored while in reset.
  always_comb begin
    state_nxt  = state;
    mem_addr   = cpu_addr;
    mem_dat_in = cpu_dat_in;
    wr_raw     = cpu_wr_en;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == 8'd0)     state_nxt = DONE;
          else if (start_fill) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_addr   = src_r + idx;
        mem_dat_in = data_buf;
        wr_raw     = 1'b0;
        state_nxt  = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        mem_addr   = dst_r + idx;
        mem_dat_in = fill_mode ? fill_data : data_buf;
        wr_raw     = 1'b1;
        if (cnt == 8'd1)    state_nxt = DONE;
        else if (fill_mode) state_nxt = WRITE;
        else                state_nxt = READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    mem_wr_en = wr_raw & ~reset;
  end

endmodule
